// File: rtl/decode_pkg.sv
// Shared decode definitions for the MIPS ID stage: opcodes, ALU ops and the control bundle.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_PASS = 4'd5
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_EQ   = 3'd1,
        BR_NE   = 3'd2,
        BR_LEZ  = 3'd3,
        BR_GTZ  = 3'd4
    } branch_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_IMM  = 2'd1,
        JMP_REG  = 2'd2
    } jump_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    mem_read;
        logic    mem_write;
        logic    alu_src;
        logic    reg_dst;
        logic    link;
        logic    uses_rs;
        logic    uses_rt;
        alu_op_e alu_op;
        branch_e branch;
        jump_e   jump;
    } ctrl_t;

    // Link register is the top entry of a 2^w-deep register file.
    function automatic int unsigned link_reg(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// 2^W x B register file: r0 hardwired to zero, synchronous write, combinational write-through read.
module regfile_bypass #(
    parameter int unsigned W = 5,
    parameter int unsigned B = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  logic [W-1:0] waddr,
    input  logic [B-1:0] wdata,
    input  logic [W-1:0] raddr1,
    input  logic [W-1:0] raddr2,
    output logic [B-1:0] rdata1_c,
    output logic [B-1:0] rdata2_c
);

    localparam int unsigned DEPTH = 1 << W;

    logic [B-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1_c = mem[raddr1];
        rdata2_c = mem[raddr2];
        if (we && (waddr == raddr1)) rdata1_c = wdata;
        if (we && (waddr == raddr2)) rdata2_c = wdata;
        if (raddr1 == '0) rdata1_c = '0;
        if (raddr2 == '0) rdata2_c = '0;
    end

endmodule

// File: rtl/instruction_decode_pipe.sv
// MIPS ID stage: decode, register read, branch/jump resolution in ID, hazard stalls and the ID/EX register.
module instruction_decode_pipe #(
    parameter int unsigned B  = 32,
    parameter int unsigned W  = 5,
    parameter int unsigned SC = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_valid,
    input  logic [B-1:0]  instruction,
    input  logic [B-1:0]  pc_incrementado,
    input  logic          wb_RegWrite,
    input  logic [W-1:0]  wb_address,
    input  logic [B-1:0]  wb_data,
    input  logic          mem_RegWrite,
    input  logic          mem_MemRead,
    input  logic [W-1:0]  mem_rd,
    input  logic [B-1:0]  mem_result,
    output logic          stall_if,
    output logic          pc_redirect,
    output logic [B-1:0]  pc_target,
    output logic          ex_valid,
    output logic          ex_RegWrite,
    output logic          ex_MemtoReg,
    output logic          ex_MemRead,
    output logic          ex_MemWrite,
    output logic          ex_ALUSrc,
    output logic [3:0]    ex_ALUOp,
    output logic [B-1:0]  ex_data1,
    output logic [B-1:0]  ex_data2,
    output logic [B-1:0]  ex_imm,
    output logic [W-1:0]  ex_rs,
    output logic [W-1:0]  ex_rt,
    output logic [W-1:0]  ex_rd,
    output logic [SC-1:0] stall_count
);
    import decode_pkg::*;

    logic [5:0]   opcode, funct;
    logic [W-1:0] rs, rt, rd, dest;
    logic [B-1:0] imm, rf_data1, rf_data2, op_a, op_b;
    ctrl_t        ctrl;
    logic         rs_ex_hit, rt_ex_hit, rs_mem_hit, rt_mem_hit;
    logic         br_rs_needed, br_rt_needed, br_stall, load_use, hazard, taken;
    logic         unused_shamt;

    assign opcode       = instruction[31:26];
    assign funct        = instruction[5:0];
    assign rs           = W'(instruction[25:21]);
    assign rt           = W'(instruction[20:16]);
    assign rd           = W'(instruction[15:11]);
    assign imm          = {{(B-16){instruction[15]}}, instruction[15:0]};
    assign unused_shamt = ^instruction[10:6];

    regfile_bypass #(.W(W), .B(B)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (wb_RegWrite),
        .waddr    (wb_address),
        .wdata    (wb_data),
        .raddr1   (rs),
        .raddr2   (rt),
        .rdata1_c (rf_data1),
        .rdata2_c (rf_data2)
    );

    // Control decode; unsupported encodings fall through as an all-zero NOP.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.uses_rs = 1'b1;
                ctrl.uses_rt = 1'b1;
                case (funct)
                    FN_ADD:  begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_ADD; end
                    FN_SUB:  begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_SUB; end
                    FN_AND:  begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_AND; end
                    FN_OR:   begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_OR;  end
                    FN_SLT:  begin ctrl.reg_write = 1'b1; ctrl.reg_dst = 1'b1; ctrl.alu_op = ALU_SLT; end
                    FN_JR:   begin ctrl.jump = JMP_REG; ctrl.alu_op = ALU_PASS; end
                    FN_JALR: begin
                        ctrl.jump      = JMP_REG;
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_dst   = 1'b1;
                        ctrl.link      = 1'b1;
                    end
                    default: begin ctrl.uses_rs = 1'b0; ctrl.uses_rt = 1'b0; end
                endcase
            end
            OP_ADDI: begin ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.uses_rs = 1'b1; end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.uses_rs    = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.uses_rs   = 1'b1;
                ctrl.uses_rt   = 1'b1;
            end
            OP_BEQ:  begin ctrl.branch = BR_EQ;  ctrl.uses_rs = 1'b1; ctrl.uses_rt = 1'b1; ctrl.alu_op = ALU_SUB; end
            OP_BNE:  begin ctrl.branch = BR_NE;  ctrl.uses_rs = 1'b1; ctrl.uses_rt = 1'b1; ctrl.alu_op = ALU_SUB; end
            OP_BLEZ: begin ctrl.branch = BR_LEZ; ctrl.uses_rs = 1'b1; ctrl.alu_op = ALU_PASS; end
            OP_BGTZ: begin ctrl.branch = BR_GTZ; ctrl.uses_rs = 1'b1; ctrl.alu_op = ALU_PASS; end
            OP_J:    begin ctrl.jump = JMP_IMM; ctrl.alu_op = ALU_PASS; end
            OP_JAL:  begin ctrl.jump = JMP_IMM; ctrl.reg_write = 1'b1; ctrl.link = 1'b1; end
            default: ;
        endcase
    end

    // Dependencies on EX and MEM producers; WB is covered by the register file bypass.
    assign rs_ex_hit  = ex_RegWrite && (ex_rd != '0) && (rs == ex_rd);
    assign rt_ex_hit  = ex_RegWrite && (ex_rd != '0) && (rt == ex_rd);
    assign rs_mem_hit = mem_RegWrite && (mem_rd != '0) && (rs == mem_rd);
    assign rt_mem_hit = mem_RegWrite && (mem_rd != '0) && (rt == mem_rd);

    assign br_rs_needed = (ctrl.branch != BR_NONE) || (ctrl.jump == JMP_REG);
    assign br_rt_needed = (ctrl.branch == BR_EQ) || (ctrl.branch == BR_NE);

    assign br_stall = (br_rs_needed && (rs_ex_hit || (rs_mem_hit && mem_MemRead)))
                   || (br_rt_needed && (rt_ex_hit || (rt_mem_hit && mem_MemRead)));

    assign load_use = ex_MemRead && (ex_rd != '0)
                   && ((ctrl.uses_rs && (rs == ex_rd)) || (ctrl.uses_rt && (rt == ex_rd)));

    assign hazard   = br_stall || load_use;
    assign stall_if = if_valid && hazard;

    assign op_a = rs_mem_hit ? mem_result : rf_data1;
    assign op_b = rt_mem_hit ? mem_result : rf_data2;

    always_comb begin
        taken = 1'b0;
        case (ctrl.branch)
            BR_EQ:   taken = (op_a == op_b);
            BR_NE:   taken = (op_a != op_b);
            BR_LEZ:  taken = op_a[B-1] || (op_a == '0);
            BR_GTZ:  taken = !op_a[B-1] && (op_a != '0);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_target = B'(pc_incrementado + B'(imm << 2));
        if (ctrl.jump == JMP_IMM) pc_target = {pc_incrementado[B-1:28], instruction[25:0], 2'b00};
        if (ctrl.jump == JMP_REG) pc_target = op_a;
    end

    assign pc_redirect = if_valid && !stall_if && (taken || (ctrl.jump != JMP_NONE));

    always_comb begin
        dest = ctrl.reg_dst ? rd : rt;
        if (ctrl.link && (ctrl.jump == JMP_IMM)) dest = W'(link_reg(W));
        if (!ctrl.reg_write) dest = '0;
    end

    // ID/EX register; a bubble clears every field.
    always_ff @(posedge clk) begin
        if (reset || !if_valid || stall_if) begin
            ex_valid    <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_ALUOp    <= '0;
            ex_data1    <= '0;
            ex_data2    <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_RegWrite <= ctrl.reg_write;
            ex_MemtoReg <= ctrl.mem_to_reg;
            ex_MemRead  <= ctrl.mem_read;
            ex_MemWrite <= ctrl.mem_write;
            ex_ALUSrc   <= ctrl.alu_src;
            ex_ALUOp    <= ctrl.alu_op;
            ex_data1    <= ctrl.link ? pc_incrementado : rf_data1;
            ex_data2    <= ctrl.link ? B'(4) : rf_data2;
            ex_imm      <= imm;
            ex_rs       <= rs;
            ex_rt       <= rt;
            ex_rd       <= dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall_if && (stall_count != '1)) begin
            stall_count <= stall_count + SC'(1);
        end
    end

endmodule

// File: tb/tb_instruction_decode_pipe.sv
// Directed self-checking bench for instruction_decode_pipe (default instance plus a 2-bit stall counter instance).
module tb_instruction_decode_pipe;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] instruction;
    logic [31:0] pc_incrementado;
    logic        wb_RegWrite;
    logic [4:0]  wb_address;
    logic [31:0] wb_data;
    logic        mem_RegWrite;
    logic        mem_MemRead;
    logic [4:0]  mem_rd;
    logic [31:0] mem_result;

    logic        stall_if, pc_redirect;
    logic [31:0] pc_target;
    logic        ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc;
    logic [3:0]  ex_ALUOp;
    logic [31:0] ex_data1, ex_data2, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [15:0] stall_count;

    logic        s_stall_if, s_pc_redirect;
    logic [31:0] s_pc_target;
    logic        s_ex_valid, s_ex_RegWrite, s_ex_MemtoReg, s_ex_MemRead, s_ex_MemWrite, s_ex_ALUSrc;
    logic [3:0]  s_ex_ALUOp;
    logic [31:0] s_ex_data1, s_ex_data2, s_ex_imm;
    logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd;
    logic [1:0]  s_stall_count;

    int checks   = 0;
    int failures = 0;

    instruction_decode_pipe #(.B(32), .W(5), .SC(16)) dut (
        .clk(clk), .reset(reset), .if_valid(if_valid), .instruction(instruction),
        .pc_incrementado(pc_incrementado), .wb_RegWrite(wb_RegWrite), .wb_address(wb_address),
        .wb_data(wb_data), .mem_RegWrite(mem_RegWrite), .mem_MemRead(mem_MemRead),
        .mem_rd(mem_rd), .mem_result(mem_result), .stall_if(stall_if), .pc_redirect(pc_redirect),
        .pc_target(pc_target), .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .stall_count(stall_count)
    );

    instruction_decode_pipe #(.B(32), .W(5), .SC(2)) dut_sat (
        .clk(clk), .reset(reset), .if_valid(if_valid), .instruction(instruction),
        .pc_incrementado(pc_incrementado), .wb_RegWrite(wb_RegWrite), .wb_address(wb_address),
        .wb_data(wb_data), .mem_RegWrite(mem_RegWrite), .mem_MemRead(mem_MemRead),
        .mem_rd(mem_rd), .mem_result(mem_result), .stall_if(s_stall_if), .pc_redirect(s_pc_redirect),
        .pc_target(s_pc_target), .ex_valid(s_ex_valid), .ex_RegWrite(s_ex_RegWrite),
        .ex_MemtoReg(s_ex_MemtoReg), .ex_MemRead(s_ex_MemRead), .ex_MemWrite(s_ex_MemWrite),
        .ex_ALUSrc(s_ex_ALUSrc), .ex_ALUOp(s_ex_ALUOp), .ex_data1(s_ex_data1), .ex_data2(s_ex_data2),
        .ex_imm(s_ex_imm), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_type(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    initial begin
        reset = 1'b1; if_valid = 1'b0; instruction = '0; pc_incrementado = '0;
        wb_RegWrite = 1'b0; wb_address = '0; wb_data = '0;
        mem_RegWrite = 1'b0; mem_MemRead = 1'b0; mem_rd = '0; mem_result = '0;
        tick();
        tick();
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_ex_regwrite", 32'(ex_RegWrite), 32'd0);
        chk("rst_ex_data1", ex_data1, 32'd0);
        chk("rst_ex_rd", 32'(ex_rd), 32'd0);
        chk("rst_stall_count", 32'(stall_count), 32'd0);
        chk("rst_stall_if", 32'(stall_if), 32'd0);
        chk("rst_pc_redirect", 32'(pc_redirect), 32'd0);
        reset = 1'b0;

        // ADD r6,r3,r0 while WB writes r3=0x1234
        if_valid = 1'b1; pc_incrementado = 32'h100;
        instruction = r_type(5'd3, 5'd0, 5'd6, 6'h20);
        wb_RegWrite = 1'b1; wb_address = 5'd3; wb_data = 32'h1234;
        tick();
        chk("bypass_data1", ex_data1, 32'h1234);
        chk("add_ex_valid", 32'(ex_valid), 32'd1);
        chk("add_ex_rd", 32'(ex_rd), 32'd6);
        chk("add_ex_regwrite", 32'(ex_RegWrite), 32'd1);

        // ADD r7,r0,r3 while WB tries to write r0
        wb_address = 5'd0; wb_data = 32'hFFFF;
        instruction = r_type(5'd0, 5'd3, 5'd7, 6'h20);
        tick();
        chk("r0_read_zero", ex_data1, 32'd0);
        chk("r3_stored", ex_data2, 32'h1234);

        // Unsupported opcode while WB writes r2=7
        wb_address = 5'd2; wb_data = 32'd7;
        instruction = 32'hFC00_0000;
        tick();
        chk("nop_ex_valid", 32'(ex_valid), 32'd1);
        chk("nop_ex_regwrite", 32'(ex_RegWrite), 32'd0);
        wb_RegWrite = 1'b0;

        // LW r2,0(r0) then ADD r4,r2,r5: one load-use stall
        instruction = i_type(6'h23, 5'd0, 5'd2, 16'd0);
        tick();
        chk("lw_ex_memread", 32'(ex_MemRead), 32'd1);
        chk("lw_ex_rd", 32'(ex_rd), 32'd2);
        chk("lw_ex_memtoreg", 32'(ex_MemtoReg), 32'd1);
        chk("lw_ex_alusrc", 32'(ex_ALUSrc), 32'd1);
        instruction = r_type(5'd2, 5'd5, 5'd4, 6'h20);
        #1;
        chk("loaduse_stall_if", 32'(stall_if), 32'd1);
        tick();
        chk("loaduse_bubble_valid", 32'(ex_valid), 32'd0);
        chk("loaduse_bubble_rd", 32'(ex_rd), 32'd0);
        chk("loaduse_stall_count", 32'(stall_count), 32'd1);
        chk("loaduse_stall_count_sat", 32'(s_stall_count), 32'd1);
        chk("loaduse_released", 32'(stall_if), 32'd0);
        tick();
        chk("add_issue_valid", 32'(ex_valid), 32'd1);
        chk("add_issue_rd", 32'(ex_rd), 32'd4);
        chk("add_issue_data1", ex_data1, 32'd7);
        chk("add_issue_count", 32'(stall_count), 32'd1);

        // BEQ r1,r2,+3 with r1 forwarded from MEM (7), r2=7
        instruction = i_type(6'h04, 5'd1, 5'd2, 16'd3); pc_incrementado = 32'h200;
        mem_RegWrite = 1'b1; mem_rd = 5'd1; mem_result = 32'd7;
        #1;
        chk("beq_fwd_stall", 32'(stall_if), 32'd0);
        chk("beq_fwd_redirect", 32'(pc_redirect), 32'd1);
        chk("beq_fwd_target", pc_target, 32'h20C);
        tick();
        mem_RegWrite = 1'b0;

        // BNE r2,r0,-1: taken backward
        instruction = i_type(6'h05, 5'd2, 5'd0, 16'hFFFF); pc_incrementado = 32'h300;
        #1;
        chk("bne_redirect", 32'(pc_redirect), 32'd1);
        chk("bne_target", pc_target, 32'h2FC);
        tick();

        // LW r1 immediately followed by BEQ r1,r0: two stalls
        instruction = i_type(6'h23, 5'd0, 5'd1, 16'd0); pc_incrementado = 32'h400;
        tick();
        instruction = i_type(6'h04, 5'd1, 5'd0, 16'd4); pc_incrementado = 32'h404;
        #1;
        chk("beq_ex_stall", 32'(stall_if), 32'd1);
        chk("beq_ex_no_redirect", 32'(pc_redirect), 32'd0);
        tick();
        mem_RegWrite = 1'b1; mem_MemRead = 1'b1; mem_rd = 5'd1; mem_result = 32'hDEAD;
        #1;
        chk("beq_mem_load_stall", 32'(stall_if), 32'd1);
        tick();
        mem_RegWrite = 1'b0; mem_MemRead = 1'b0;
        wb_RegWrite = 1'b1; wb_address = 5'd1; wb_data = 32'd9;
        #1;
        chk("beq_wb_no_stall", 32'(stall_if), 32'd0);
        chk("beq_wb_not_taken", 32'(pc_redirect), 32'd0);
        chk("beq_stall_count", 32'(stall_count), 32'd3);
        chk("beq_stall_count_sat", 32'(s_stall_count), 32'd3);
        tick();
        wb_RegWrite = 1'b0;
        chk("beq_enters_ex", 32'(ex_valid), 32'd1);

        // JAL
        instruction = j_type(6'h03, 26'h0100000); pc_incrementado = 32'h0040_0004;
        #1;
        chk("jal_redirect", 32'(pc_redirect), 32'd1);
        chk("jal_target", pc_target, 32'h0040_0000);
        tick();
        chk("jal_ex_rd", 32'(ex_rd), 32'd31);
        chk("jal_ex_data1", ex_data1, 32'h0040_0004);
        chk("jal_ex_data2", ex_data2, 32'd4);
        chk("jal_ex_regwrite", 32'(ex_RegWrite), 32'd1);
        chk("jal_ex_aluop", 32'(ex_ALUOp), 32'd0);

        // BLEZ r8 with r8=0x80000000 via bypass
        wb_RegWrite = 1'b1; wb_address = 5'd8; wb_data = 32'h8000_0000;
        instruction = i_type(6'h06, 5'd8, 5'd0, 16'd1); pc_incrementado = 32'h500;
        #1;
        chk("blez_neg_taken", 32'(pc_redirect), 32'd1);
        chk("blez_target", pc_target, 32'h504);
        tick();
        wb_RegWrite = 1'b0;

        // BGTZ r0 not taken, BGTZ r2 (7) taken
        instruction = i_type(6'h07, 5'd0, 5'd0, 16'd1);
        #1;
        chk("bgtz_zero_not_taken", 32'(pc_redirect), 32'd0);
        instruction = i_type(6'h07, 5'd2, 5'd0, 16'd2); pc_incrementado = 32'h600;
        #1;
        chk("bgtz_pos_taken", 32'(pc_redirect), 32'd1);
        chk("bgtz_target", pc_target, 32'h608);
        tick();

        // Hold a MEM load hazard on BEQ r1,r0 for five cycles
        instruction = i_type(6'h04, 5'd1, 5'd0, 16'd4);
        mem_RegWrite = 1'b1; mem_MemRead = 1'b1; mem_rd = 5'd1;
        repeat (5) tick();
        chk("hold_stall_count", 32'(stall_count), 32'd8);
        chk("hold_stall_count_sat", 32'(s_stall_count), 32'd3);
        chk("hold_bubble", 32'(ex_valid), 32'd0);

        // Reset mid-stall
        reset = 1'b1;
        #1;
        chk("rst_mid_stall_if", 32'(stall_if), 32'd1);
        tick();
        chk("rst_mid_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_mid_count", 32'(stall_count), 32'd0);
        chk("rst_mid_count_sat", 32'(s_stall_count), 32'd0);
        reset = 1'b0; if_valid = 1'b0;
        mem_RegWrite = 1'b0; mem_MemRead = 1'b0;
        #1;
        chk("invalid_stall_if", 32'(stall_if), 32'd0);
        chk("invalid_redirect", 32'(pc_redirect), 32'd0);

        // Register file cleared by reset: r1 and r2 read 0
        if_valid = 1'b1;
        instruction = r_type(5'd1, 5'd2, 5'd10, 6'h20);
        tick();
        chk("rf_clear_data1", ex_data1, 32'd0);
        chk("rf_clear_data2", ex_data2, 32'd0);
        if_valid = 1'b0;
        tick();
        chk("invalid_bubble", 32'(ex_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_decode_pipe.md
# instruction_decode_pipe

Parametrised ID stage for the 5-stage MIPS pipeline.
- Decodes the instruction and reads a 2^W-entry register file with write-through bypass.
- Resolves branches and jumps in ID, with forwarding from MEM and its own hazard detection.
- Drives a registered ID/EX pipeline register with bubble insertion.
- Sits between the IF/ID register and the EX stage, and owns the stall and flush requests back to IF.

## Interface
Parameters:
- B, 32, datapath and instruction width (≥32; instruction fields taken from bits [31:0])
- W, 5, register address width; register file depth 2^W
- SC, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- if_valid  in  1  instruction and pc_incrementado are valid
- instruction  in  B  fetched instruction
- pc_incrementado  in  B  PC+4 of the instruction
- wb_RegWrite  in  1  WB write enable
- wb_address  in  W  WB destination
- wb_data  in  B  WB data
- mem_RegWrite  in  1  MEM-stage instruction writes a register
- mem_MemRead  in  1  MEM-stage instruction is a load
- mem_rd  in  W  MEM-stage destination
- mem_result  in  B  MEM-stage ALU result (forward source)
- stall_if  out  1  hold PC and IF/ID this cycle (combinational)
- pc_redirect  out  1  taken branch/jump; IF loads pc_target and flushes IF/ID (combinational)
- pc_target  out  B  redirect address
- ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemRead, ex_MemWrite, ex_ALUSrc  out  1 each  registered controls
- ex_ALUOp  out  4  registered ALU operation code (package enum)
- ex_data1, ex_data2, ex_imm  out  B  registered operands and sign-extended immediate
- ex_rs, ex_rt, ex_rd  out  W  registered source and final destination (RegDst/link already resolved)
- stall_count  out  SC  saturating count of stall cycles

## Operation
Supported instructions:
- R-type: ADD, SUB, AND, OR, SLT, JR, JALR
- Other: ADDI, LW, SW, BEQ, BNE, BLEZ, BGTZ, J, JAL
- Anything else decodes as a NOP: all write/mem controls 0, ex_valid still 1.

Register file:
- Synchronous write when wb_RegWrite && wb_address≠0.
- Combinational read; a read of address 0 returns 0.
- Same-cycle write bypass: reading wb_address returns wb_data.
- Reset clears all entries to 0.

Destination:
- I-type writes rt; R-type writes rd.
- JAL writes 2^W−1; JALR writes rd.
- Links write data1 = pc_incrementado and data2 = 4, with ALUOp = ADD.

Branch/jump operand (rs, plus rt for BEQ/BNE) resolution, in priority order:
1. Operand matches ex_rd while ex_RegWrite && ex_rd≠0 → stall.
2. Operand matches mem_rd while mem_RegWrite && mem_rd≠0: if mem_MemRead → stall; otherwise forward mem_result.
3. Otherwise use the register file value.

Load-use hazard:
- Any instruction reading rs/rt (rt only for R-type, BEQ, BNE, SW) stalls when ex_MemRead && ex_rd≠0 && ex_rd matches.

Branch conditions:
- BEQ: a==b. BNE: a≠b.
- BLEZ: signed a≤0. BGTZ: signed a>0.

Targets:
- Branch: pc_incrementado + (imm<<2), modulo 2^B.
- J/JAL: {pc_incrementado[B-1:28], instr[25:0], 2'b00}.
- JR/JALR: the resolved rs.

Stall and redirect rules:
- stall_if = if_valid && hazard.
- pc_redirect = if_valid && !stall_if && (branch taken || jump).

stall_count:
- Increments every cycle stall_if=1.
- Saturates at 2^SC−1.

## Timing
- All ex_* outputs update on the rising edge: one cycle of latency from ID to EX.
- A bubble loads when reset, !if_valid, or stall_if: every ex_* output becomes 0, and ex_rd becomes 0.
- Otherwise the ID/EX register loads the decoded values with ex_valid=1.
- A redirecting instruction itself enters ID/EX normally (links need it).
- Reset values: every ex_* output 0, stall_count 0, register file all 0. stall_if and pc_redirect follow inputs combinationally; they are 0 while if_valid=0.
- Reset asserted mid-stall: next cycle all state is 0, and the stall is lost (IF is reset too).
- Simultaneous WB write and hazard: the bypass value is used, and the hazard decision is unaffected by WB.
- A stall lasts one cycle per unresolved dependency. A branch after a load with one instruction between them stalls 1 cycle; a branch immediately after a load stalls 2 cycles.

## Structure
- Package decode_pkg holds:
  - opcode/funct localparams
  - the ALU-op enum (ADD, SUB, AND, OR, SLT, PASS)
  - the link register index
  - a ctrl struct (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, Branch kind, Jump kind)
- One sub-module, regfile_bypass: the parametrised register file (W, B) with reset clear and write-through.
- Decode, hazard, branch and pipeline-register logic stay in the top module.

## Test plan
- Reset, then write wb_address=3, wb_data=0x1234 and read rs=3 in the same cycle → ex_data1=0x1234 next edge. Writing to r0 → reads stay 0.
- LW r2 in EX, then ADD r4,r2,r5 in ID → stall_if=1 for 1 cycle, bubble in EX (ex_valid=0), stall_count=1, ADD issues the next cycle.
- BEQ r1,r2 with mem_rd=1, mem_result=7, r2=7, mem_MemRead=0 → pc_redirect=1, pc_target = pc_incrementado + (imm<<2), no stall.
- LW r1 immediately followed by BEQ r1,r0 → 2 stall cycles, then branch resolved using the register value via the WB bypass.
- JAL 0x0100000 at pc_incrementado=0x00400004 → pc_target=0x00400000, ex_rd=31, ex_data1=0x00400004, ex_data2=4. BLEZ with rs=0x80000000 → taken. BGTZ with rs=0 → not taken.
- SC=2, hold a hazard for 5 cycles → stall_count saturates at 3. Reset asserted mid-stall → all outputs 0 on the next edge.
